// File: rtl/pdp8_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pdp8_pkg                                                      |
// | Purpose  : Opcode structures shared by the PDP-8 core.                  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package pdp8_pkg;

    typedef struct packed {
        logic       AND;
        logic       TAD;
        logic       ISZ;
        logic       DCA;
        logic       JMS;
        logic       JMP;
        logic [8:0] mem_inst_addr;
    } pdp_mem_opcode_s;

    typedef struct packed {
        logic NOP;
        logic IAC;
        logic RAL;
        logic RTL;
        logic RAR;
        logic RTR;
        logic CML;
        logic CMA;
        logic CIA;
        logic CLL;
        logic CLA1;
        logic CLA_CLL;
        logic HLT;
        logic OSR;
        logic SKP;
        logic SNL;
        logic SZL;
        logic SZA;
        logic SNA;
        logic SMA;
        logic SPA;
        logic CLA2;
    } pdp_op7_opcode_s;

endpackage
`default_nettype wire

// File: rtl/pdp8_instr_fetch_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pdp8_instr_fetch_decode                                       |
// | Purpose  : Fetches the word at PC over req/ack, decodes and presents it.|
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module pdp8_instr_fetch_decode
    import pdp8_pkg::*;
#(
    parameter int                    ADDR_WIDTH    = 12,
    parameter int                    DATA_WIDTH    = 12,
    parameter logic [ADDR_WIDTH-1:0] START_ADDRESS = 'o200,
    parameter int                    FETCH_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  stall,
    input  logic [ADDR_WIDTH-1:0] PC_value,
    output logic                  rd_req,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_ack,
    input  logic                  exec_done,
    output logic                  decode_valid,
    output logic [ADDR_WIDTH-1:0] base_addr,
    output pdp_mem_opcode_s       pdp_mem_opcode,
    output pdp_op7_opcode_s       pdp_op7_opcode,
    output logic                  illegal_op,
    output logic                  fetch_err
);

    localparam int c_CNT_W = $clog2(FETCH_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_DECODE  = 2'd2,
        S_PRESENT = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  w_req;
    logic                  w_timeout;
    logic                  w_enter_fetch;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_gap;
    logic [DATA_WIDTH-1:0] r_word;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [ADDR_WIDTH-1:0] r_base;
    pdp_mem_opcode_s       r_mem;
    pdp_op7_opcode_s       r_op7;
    logic                  r_illegal;
    logic                  r_fetch_err;
    logic [2:0]            w_opc;
    logic                  w_is_mem;
    logic                  w_illegal;
    logic [ADDR_WIDTH-1:0] w_base;
    pdp_mem_opcode_s       w_mem;
    pdp_op7_opcode_s       w_op7;

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // r_gap forces one idle cycle on the bus before a timed-out read is re-issued
    always_comb begin
        w_next = r_state;
        w_req  = 1'b0;
        case (r_state)
            S_IDLE:    if (!stall) w_next = S_FETCH;
            S_FETCH: begin
                w_req = !stall && !r_gap;
                if (w_req && rd_ack) w_next = S_DECODE;
            end
            S_DECODE:  w_next = S_PRESENT;
            S_PRESENT: if (exec_done && !stall) w_next = S_FETCH;
            default:   w_next = S_IDLE;
        endcase
    end

    assign w_enter_fetch = (w_next == S_FETCH) && (r_state != S_FETCH);
    assign w_timeout     = w_req && !rd_ack && (r_cnt == c_CNT_W'(FETCH_TIMEOUT - 1));
    assign w_opc         = r_word[DATA_WIDTH-1 -: 3];

    always_comb begin
        w_mem     = '0;
        w_op7     = '0;
        w_illegal = 1'b0;
        w_is_mem  = (w_opc < 3'd6);
        w_base    = {{(ADDR_WIDTH-7){1'b0}}, r_word[6:0]};
        if (r_word[7]) w_base = {r_rd_addr[ADDR_WIDTH-1:7], r_word[6:0]};
        case (w_opc)
            3'd0: w_mem.AND = 1'b1;
            3'd1: w_mem.TAD = 1'b1;
            3'd2: w_mem.ISZ = 1'b1;
            3'd3: w_mem.DCA = 1'b1;
            3'd4: w_mem.JMS = 1'b1;
            3'd5: w_mem.JMP = 1'b1;
            3'd6: w_illegal = 1'b1;
            default: begin
                case (r_word[8:0])
                    9'o000:  w_op7.NOP     = 1'b1;
                    9'o001:  w_op7.IAC     = 1'b1;
                    9'o004:  w_op7.RAL     = 1'b1;
                    9'o006:  w_op7.RTL     = 1'b1;
                    9'o010:  w_op7.RAR     = 1'b1;
                    9'o012:  w_op7.RTR     = 1'b1;
                    9'o020:  w_op7.CML     = 1'b1;
                    9'o040:  w_op7.CMA     = 1'b1;
                    9'o041:  w_op7.CIA     = 1'b1;
                    9'o100:  w_op7.CLL     = 1'b1;
                    9'o200:  w_op7.CLA1    = 1'b1;
                    9'o300:  w_op7.CLA_CLL = 1'b1;
                    9'o402:  w_op7.HLT     = 1'b1;
                    9'o404:  w_op7.OSR     = 1'b1;
                    9'o410:  w_op7.SKP     = 1'b1;
                    9'o420:  w_op7.SNL     = 1'b1;
                    9'o430:  w_op7.SZL     = 1'b1;
                    9'o440:  w_op7.SZA     = 1'b1;
                    9'o450:  w_op7.SNA     = 1'b1;
                    9'o500:  w_op7.SMA     = 1'b1;
                    9'o510:  w_op7.SPA     = 1'b1;
                    9'o600:  w_op7.CLA2    = 1'b1;
                    default: w_illegal     = 1'b1;
                endcase
            end
        endcase
        if (w_is_mem) w_mem.mem_inst_addr = r_word[8:0];
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_cnt       <= '0;
            r_gap       <= 1'b0;
            r_word      <= '0;
            r_rd_addr   <= '0;
            r_base      <= START_ADDRESS;
            r_mem       <= '0;
            r_op7       <= '0;
            r_illegal   <= 1'b0;
            r_fetch_err <= 1'b0;
        end else begin
            r_gap <= 1'b0;
            if (w_enter_fetch) begin
                r_rd_addr <= PC_value;
                r_cnt     <= '0;
            end else if (w_req) begin
                if (rd_ack) begin
                    r_word <= rd_data;
                    r_cnt  <= '0;
                end else if (w_timeout) begin
                    r_cnt       <= '0;
                    r_gap       <= 1'b1;
                    r_fetch_err <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end
            // base_addr only tracks memory-reference instructions
            if (r_state == S_DECODE) begin
                r_mem     <= w_mem;
                r_op7     <= w_op7;
                r_illegal <= w_illegal;
                if (w_is_mem) r_base <= w_base;
            end
        end
    end

    assign rd_req         = w_req;
    assign rd_addr        = r_rd_addr;
    assign decode_valid   = (r_state == S_PRESENT);
    assign base_addr      = r_base;
    assign pdp_mem_opcode = r_mem;
    assign pdp_op7_opcode = r_op7;
    assign illegal_op     = r_illegal;
    assign fetch_err      = r_fetch_err;

endmodule
`default_nettype wire

// File: tb/tb_pdp8_instr_fetch_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pdp8_instr_fetch_decode                                    |
// | Purpose  : Randomised self-checking bench against a behavioural model.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_pdp8_instr_fetch_decode;

    localparam int          c_TO    = 15;
    localparam logic [11:0] c_START = 12'o200;
    localparam logic [11:0] c_OP7_TBL [0:21] = '{
        12'o7000, 12'o7001, 12'o7004, 12'o7006, 12'o7010, 12'o7012,
        12'o7020, 12'o7040, 12'o7041, 12'o7100, 12'o7200, 12'o7300,
        12'o7402, 12'o7404, 12'o7410, 12'o7420, 12'o7430, 12'o7440,
        12'o7450, 12'o7500, 12'o7510, 12'o7600};

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        stall = 1'b0;
    logic [11:0] PC_value = '0;
    logic        rd_req;
    logic [11:0] rd_addr;
    logic [11:0] rd_data = '0;
    logic        rd_ack = 1'b0;
    logic        exec_done = 1'b0;
    logic        decode_valid;
    logic [11:0] base_addr;
    pdp8_pkg::pdp_mem_opcode_s pdp_mem_opcode;
    pdp8_pkg::pdp_op7_opcode_s pdp_op7_opcode;
    logic        illegal_op;
    logic        fetch_err;

    pdp8_instr_fetch_decode #(
        .ADDR_WIDTH   (12),
        .DATA_WIDTH   (12),
        .START_ADDRESS(c_START),
        .FETCH_TIMEOUT(c_TO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall         (stall),
        .PC_value      (PC_value),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_ack        (rd_ack),
        .exec_done     (exec_done),
        .decode_valid  (decode_valid),
        .base_addr     (base_addr),
        .pdp_mem_opcode(pdp_mem_opcode),
        .pdp_op7_opcode(pdp_op7_opcode),
        .illegal_op    (illegal_op),
        .fetch_err     (fetch_err)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [14:0] e_mem  = '0;
    logic [21:0] e_op7  = '0;
    logic        e_ill  = 1'b0;
    logic [11:0] e_base = c_START;
    logic        e_err  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        e_mem = '0; e_op7 = '0; e_ill = 1'b0; e_base = c_START; e_err = 1'b0;
    endtask

    // Reference decode: opcode class from the top three bits, op7 by table lookup
    task automatic model_decode(input logic [11:0] w, input logic [11:0] pc);
        int opc   = int'(w[11:9]);
        bit found = 1'b0;
        e_mem = '0; e_op7 = '0; e_ill = 1'b0;
        if (opc < 6) begin
            e_mem  = 15'(15'h4000 >> opc) | 15'(w[8:0]);
            e_base = (w[7] ? (pc & 12'o7600) : 12'o0) | (w & 12'o177);
        end else if (opc == 6) begin
            e_ill = 1'b1;
        end else begin
            for (int i = 0; i < 22; i++)
                if (c_OP7_TBL[i] == w) begin
                    e_op7 = 22'(1) << (21 - i);
                    found = 1'b1;
                end
            e_ill = !found;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".mem"}, 32'(pdp_mem_opcode), 32'(e_mem));
        chk({tag, ".op7"}, 32'(pdp_op7_opcode), 32'(e_op7));
        chk({tag, ".illegal"}, 32'(illegal_op), 32'(e_ill));
        chk({tag, ".base"}, 32'(base_addr), 32'(e_base));
        chk({tag, ".fetch_err"}, 32'(fetch_err), 32'(e_err));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".rd_req"}, 32'(rd_req), 0);
        chk({tag, ".rd_addr"}, 32'(rd_addr), 0);
        chk({tag, ".dv"}, 32'(decode_valid), 0);
        check_outputs(tag);
    endtask

    task automatic start_fetch(input logic [11:0] pc);
        PC_value = pc; stall = 1'b0; exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        PC_value  = 12'($urandom);
        #1;
        chk("req_after_release", 32'(rd_req), 1);
        chk("rd_addr_entry", 32'(rd_addr), 32'(pc));
        chk("dv_low_in_fetch", 32'(decode_valid), 0);
        check_outputs("hold_in_fetch");
    endtask

    task automatic fetch_stall(input logic [11:0] pc, input int k);
        for (int i = 0; i < k; i++) begin
            stall = 1'b1; rd_ack = 1'($urandom); rd_data = 12'($urandom);
            #1;
            chk("req_stalled", 32'(rd_req), 0);
            tick();
        end
        stall = 1'b0; rd_ack = 1'b0;
        #1;
        chk("req_resume", 32'(rd_req), 1);
        chk("addr_resume", 32'(rd_addr), 32'(pc));
    endtask

    task automatic complete(input logic [11:0] word, input logic [11:0] pc, input int delay);
        for (int i = 0; i < delay; i++) begin
            chk("req_wait", 32'(rd_req), 1);
            tick();
        end
        rd_ack = 1'b1; rd_data = word;
        #1;
        chk("req_at_ack", 32'(rd_req), 1);
        tick();
        rd_ack = 1'b0; rd_data = 12'($urandom);
        #1;
        chk("dv_decode_cycle", 32'(decode_valid), 0);
        chk("req_decode_cycle", 32'(rd_req), 0);
        tick();
        #1;
        model_decode(word, pc);
        chk("dv_ack_plus2", 32'(decode_valid), 1);
        chk("req_present", 32'(rd_req), 0);
        check_outputs("present");
    endtask

    task automatic present_stall(input int k);
        for (int i = 0; i < k; i++) begin
            stall = 1'b1; exec_done = 1'b1;
            #1;
            chk("dv_stalled", 32'(decode_valid), 1);
            chk("req_stalled_present", 32'(rd_req), 0);
            check_outputs("stall_present");
            tick();
        end
        stall = 1'b0; exec_done = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] pc;
        logic [11:0] w;
        int          n;

        repeat (3) tick();
        check_reset("por");
        reset_n = 1'b0; stall = 1'b1;
        tick(); tick();
        chk("idle_stalled_req", 32'(rd_req), 0);

        // TAD at the reset page
        start_fetch(12'o200);
        complete(12'o1205, 12'o200, 3);
        chk("tad_flag", 32'(pdp_mem_opcode.TAD), 1);
        chk("tad_addr", 32'(pdp_mem_opcode.mem_inst_addr), 32'(9'o205));
        chk("tad_base", 32'(base_addr), 32'(12'o205));

        // DCA page zero
        start_fetch(12'o4510);
        complete(12'o3020, 12'o4510, 1);
        chk("dca_flag", 32'(pdp_mem_opcode.DCA), 1);
        chk("dca_base", 32'(base_addr), 32'(12'o0020));

        // IAC
        start_fetch(12'o4511);
        complete(12'o7001, 12'o4511, 0);
        chk("iac_flag", 32'(pdp_op7_opcode.IAC), 1);
        chk("iac_onehot", 32'($countones(pdp_op7_opcode)), 1);
        chk("iac_mem_zero", 32'(pdp_mem_opcode), 0);

        // IOT is illegal
        start_fetch(12'o4512);
        complete(12'o6001, 12'o4512, 2);
        chk("iot_illegal", 32'(illegal_op), 1);
        chk("iot_mem_zero", 32'(pdp_mem_opcode), 0);
        chk("iot_op7_zero", 32'(pdp_op7_opcode), 0);

        // Timeout and retry
        start_fetch(12'o1000);
        n = 0;
        while (rd_req === 1'b1 && n < 40) begin
            n++;
            tick();
            #1;
        end
        chk("timeout_len", 32'(n), c_TO);
        chk("timeout_gap_req", 32'(rd_req), 0);
        chk("timeout_err", 32'(fetch_err), 1);
        e_err = 1'b1;
        tick();
        #1;
        chk("retry_req", 32'(rd_req), 1);
        chk("retry_addr", 32'(rd_addr), 32'(12'o1000));
        complete(12'o5123, 12'o1000, 2);

        // Stall in FETCH and PRESENT
        start_fetch(12'o3000);
        fetch_stall(12'o3000, 4);
        complete(12'o2377, 12'o3000, 2);
        present_stall(3);

        // Reset mid-FETCH, then a late ack
        start_fetch(12'o2000);
        tick();
        reset_n = 1'b1;
        model_reset();
        #1;
        check_reset("rst_fetch");
        rd_ack = 1'b1; stall = 1'b1;
        tick();
        reset_n = 1'b0;
        tick();
        rd_ack = 1'b0;
        #1;
        chk("late_ack_dv", 32'(decode_valid), 0);
        chk("late_ack_req", 32'(rd_req), 0);
        start_fetch(12'o2000);
        complete(12'o0456, 12'o2000, 1);

        // Reset mid-PRESENT
        reset_n = 1'b1;
        model_reset();
        #1;
        check_reset("rst_present");
        tick();
        reset_n = 1'b0;

        for (int t = 0; t < 40; t++) begin
            pc = 12'($urandom);
            case ($urandom_range(0, 3))
                0, 1:    w = {3'($urandom_range(0, 5)), 9'($urandom)};
                2:       w = c_OP7_TBL[$urandom_range(0, 21)];
                default: w = {3'($urandom_range(6, 7)), 9'($urandom)};
            endcase
            start_fetch(pc);
            fetch_stall(pc, $urandom_range(0, 5));
            complete(w, pc, $urandom_range(0, 10));
            present_stall($urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
